// File: rtl/cic_decim_back_end_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg : shared helpers for the CIC decimator back end.
//   clog2()      : ceiling log2, usable in constant expressions.
//   rate_width() : width of the active-rate register and decimation counter.
//                  With a runtime-programmable rate the counter must span the
//                  full rate input. With a fixed rate it only needs to hold
//                  values up to CIC_R.
// -----------------------------------------------------------------------------
package cic_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int rate_width(input int cic_r, input int rate_dw, input bit var_en);
        int w;
        if (var_en) begin
            w = rate_dw;
        end else begin
            w = clog2(cic_r + 1);
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cic_decim_back_end_if.sv
// -----------------------------------------------------------------------------
// cic_decim_back_end_if : stream bundle around the CIC decimator back end.
//   s_axis_in_*   : integrator-chain samples (no backpressure).
//   s_axis_rate_* : decimation-ratio load.
//   m_axis_out_*  : decimated, comb-filtered output with a one-cycle strobe.
// Modports: slave  = the decimator (consumes inputs, drives outputs)
//           master = the environment driving it
// -----------------------------------------------------------------------------
interface cic_decim_back_end_if #(
    parameter int DW      = 32,
    parameter int OUT_DW  = 32,
    parameter int RATE_DW = 32
) ();
    logic [DW-1:0]      s_axis_in_tdata;
    logic               s_axis_in_tvalid;
    logic [RATE_DW-1:0] s_axis_rate_tdata;
    logic               s_axis_rate_tvalid;
    logic [OUT_DW-1:0]  m_axis_out_tdata;
    logic               m_axis_out_tvalid;

    modport slave (
        input  s_axis_in_tdata, s_axis_in_tvalid,
        input  s_axis_rate_tdata, s_axis_rate_tvalid,
        output m_axis_out_tdata, m_axis_out_tvalid
    );

    modport master (
        output s_axis_in_tdata, s_axis_in_tvalid,
        output s_axis_rate_tdata, s_axis_rate_tvalid,
        input  m_axis_out_tdata, m_axis_out_tvalid
    );
endinterface

// File: rtl/cic_decim_back_end_comb_stage.sv
// -----------------------------------------------------------------------------
// cic_comb_stage : one CIC comb section, y = x - x[n - CIC_M].
// The delay line advances only on input strobes, so it counts decimated
// samples rather than clock cycles. The result and strobe are registered,
// which gives one cycle of latency. The arithmetic wraps modulo 2^DW.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   x_i, vld_i   : input sample and strobe
//   y_o, vld_o   : registered difference and strobe
// -----------------------------------------------------------------------------
module cic_comb_stage #(
    parameter int DW    = 32,
    parameter int CIC_M = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] x_i,
    input  logic          vld_i,
    output logic [DW-1:0] y_o,
    output logic          vld_o
);

    logic [DW-1:0] dly_q [CIC_M];
    logic [DW-1:0] y_q;
    logic          vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the delay line is only CIC_M words and must start at zero
            // for the first outputs to be correct, so it is reset like any
            // other register rather than inferred as RAM.
            for (int i = 0; i < CIC_M; i++) begin
                dly_q[i] <= '0;
            end
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                y_q      <= x_i - dly_q[CIC_M-1];
                dly_q[0] <= x_i;
                for (int i = 1; i < CIC_M; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end
    end

    assign y_o   = y_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/cic_decim_back_end.sv
// -----------------------------------------------------------------------------
// cic_decim_back_end : decimator and comb chain of a CIC decimation filter.
// Every R-th valid integrator sample is kept. The kept sample goes through
// CIC_N comb stages. The top OUT_DW bits of the last stage are registered as
// the output. The latency from the accepting input edge to the output strobe
// is CIC_N+2 cycles.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : s_axis_in_*, s_axis_rate_*, m_axis_out_* stream signals
// Build option:
//   CIC_VARIABLE_RATE_EN : when this is defined, s_axis_rate_* loads the ratio
//                          at run time and a ratio of 0 acts as 1. When it is
//                          not defined, the ratio is fixed at CIC_R and the
//                          rate inputs are ignored.
// -----------------------------------------------------------------------------
module cic_decim_back_end
    import cic_pkg::*;
#(
    parameter int DW      = 32,
    parameter int OUT_DW  = 32,
    parameter int RATE_DW = 32,
    parameter int CIC_R   = 10,
    parameter int CIC_N   = 7,
    parameter int CIC_M   = 1
) (
    input logic                 clk,
    input logic                 reset_n,
    cic_decim_back_end_if.slave bus
);

`ifdef CIC_VARIABLE_RATE_EN
    localparam bit VarRateEn = 1'b1;
`else
    localparam bit VarRateEn = 1'b0;
`endif
    localparam int RW = rate_width(CIC_R, RATE_DW, VarRateEn);

    logic          load;
    logic [RW-1:0] rate;

`ifdef CIC_VARIABLE_RATE_EN
    logic [RW-1:0] rate_q, rate_d;

    assign load = bus.s_axis_rate_tvalid;

    always_comb begin
        rate_d = rate_q;
        if (load) begin
            rate_d = (bus.s_axis_rate_tdata == '0) ? RW'(1) : bus.s_axis_rate_tdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rate_q <= RW'(CIC_R);
        else          rate_q <= rate_d;
    end

    assign rate = rate_q;
`else
    logic unused_rate;
    assign unused_rate = ^{bus.s_axis_rate_tdata, bus.s_axis_rate_tvalid};
    assign load        = 1'b0;
    assign rate        = RW'(CIC_R);
`endif

    // Downsampler: count valid samples and accept the one where count == R-1.
    logic [RW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] acc_data_q, acc_data_d;
    logic          acc_vld_q, acc_vld_d;
    logic [DW-1:0] ds_data_q;
    logic          ds_vld_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        cnt_d      = cnt_q;
        acc_data_d = acc_data_q;
        acc_vld_d  = 1'b0;
        if (load) begin
            // A rate load restarts the count. A sample arriving with it is dropped.
            cnt_d = '0;
        end else if (bus.s_axis_in_tvalid) begin
            if (cnt_q == rate - RW'(1)) begin
                cnt_d      = '0;
                acc_data_d = bus.s_axis_in_tdata;
                acc_vld_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            acc_data_q <= '0;
            acc_vld_q  <= 1'b0;
            ds_data_q  <= '0;
            ds_vld_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples its inputs as they were before this edge.
            cnt_q      <= cnt_d;
            acc_data_q <= acc_data_d;
            acc_vld_q  <= acc_vld_d;
            // The accepted sample is retimed once more before the comb chain.
            ds_data_q  <= acc_data_q;
            ds_vld_q   <= acc_vld_q;
        end
    end

    // Comb chain: element 0 is the decimated stream, element k+1 is the output of stage k.
    logic [CIC_N:0][DW-1:0] stg_data;
    logic [CIC_N:0]         stg_vld;

    assign stg_data[0] = ds_data_q;
    assign stg_vld[0]  = ds_vld_q;

    for (genvar k = 0; k < CIC_N; k++) begin : g_comb
        cic_comb_stage #(
            .DW    (DW),
            .CIC_M (CIC_M)
        ) u_comb (
            .clk     (clk),
            .reset_n (reset_n),
            .x_i     (stg_data[k]),
            .vld_i   (stg_vld[k]),
            .y_o     (stg_data[k+1]),
            .vld_o   (stg_vld[k+1])
        );
    end

    logic [OUT_DW-1:0] out_data_q;
    logic              out_vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            out_vld_q <= stg_vld[CIC_N];
            if (stg_vld[CIC_N]) begin
                out_data_q <= stg_data[CIC_N][DW-1 -: OUT_DW];
            end
        end
    end

    assign bus.m_axis_out_tdata  = out_data_q;
    assign bus.m_axis_out_tvalid = out_vld_q;

endmodule

// File: tb/tb_cic_decim_back_end.sv
// -----------------------------------------------------------------------------
// tb_cic_decim_back_end : directed test of the CIC decimator back end.
// Main DUT: DW=16, OUT_DW=16, CIC_R=4, CIC_N=2, CIC_M=1.
// Wrap DUT: DW=8, OUT_DW=8, CIC_R=1, CIC_N=1, CIC_M=1.
// Inputs are driven 1 ns after a rising edge, and outputs are sampled at the
// same point.
// -----------------------------------------------------------------------------
module tb_cic_decim_back_end;

    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cic_decim_back_end_if #(.DW(16), .OUT_DW(16), .RATE_DW(32)) bus ();
    cic_decim_back_end_if #(.DW(8),  .OUT_DW(8),  .RATE_DW(8))  wbus ();

    cic_decim_back_end #(
        .DW(16), .OUT_DW(16), .RATE_DW(32), .CIC_R(4), .CIC_N(2), .CIC_M(1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    cic_decim_back_end #(
        .DW(8), .OUT_DW(8), .RATE_DW(8), .CIC_R(1), .CIC_N(1), .CIC_M(1)
    ) dut_w (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (wbus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One record per clock cycle: the inputs driven and the output expected after the edge.
    typedef struct {
        logic        vld;
        logic [15:0] x;
        logic        exp_vld;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl [40];
    int   tbl_len;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } ev_t;

    ev_t got[$];
    ev_t wgot[$];
    int  cyc;

    task automatic tbl_clear(input int n);
        tbl_len = n;
        for (int i = 0; i < 40; i++) begin
            tbl[i] = '{vld: 1'b0, x: 16'h0, exp_vld: 1'b0, exp_data: 16'h0};
        end
    endtask

    // tdata holds between strobes, so carry the last expected value forward.
    task automatic tbl_hold();
        logic [15:0] h;
        h = 16'h0;
        for (int i = 0; i < tbl_len; i++) begin
            if (tbl[i].exp_vld) h = tbl[i].exp_data;
            else                tbl[i].exp_data = h;
        end
    endtask

    task automatic idle_inputs();
        bus.s_axis_in_tdata    = '0;
        bus.s_axis_in_tvalid   = 1'b0;
        bus.s_axis_rate_tdata  = '0;
        bus.s_axis_rate_tvalid = 1'b0;
        wbus.s_axis_in_tdata    = '0;
        wbus.s_axis_in_tvalid   = 1'b0;
        wbus.s_axis_rate_tdata  = '0;
        wbus.s_axis_rate_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_table(input string name);
        do_reset();
        for (int i = 0; i < tbl_len; i++) begin
            bus.s_axis_in_tvalid = tbl[i].vld;
            bus.s_axis_in_tdata  = tbl[i].x;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d].tvalid", name, i), 32'(bus.m_axis_out_tvalid), 32'(tbl[i].exp_vld));
            check($sformatf("%s[%0d].tdata", name, i), 32'(bus.m_axis_out_tdata), 32'(tbl[i].exp_data));
        end
        idle_inputs();
    endtask

    task automatic step(input logic v, input logic [15:0] x, input logic rv, input logic [31:0] r);
        bus.s_axis_in_tvalid   = v;
        bus.s_axis_in_tdata    = x;
        bus.s_axis_rate_tvalid = rv;
        bus.s_axis_rate_tdata  = r;
        @(posedge clk);
        #1;
        if (bus.m_axis_out_tvalid)  got.push_back('{cyc, bus.m_axis_out_tdata});
        if (wbus.m_axis_out_tvalid) wgot.push_back('{cyc, {8'h00, wbus.m_axis_out_tdata}});
        cyc++;
    endtask

    task automatic check_events(input string name, input ev_t exp_ev[$], input ev_t act_ev[$]);
        int n;
        check({name, ".count"}, 32'(act_ev.size()), 32'(exp_ev.size()));
        n = (act_ev.size() < exp_ev.size()) ? act_ev.size() : exp_ev.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d].cycle", name, i), 32'(act_ev[i].cyc), 32'(exp_ev[i].cyc));
            check($sformatf("%s[%0d].tdata", name, i), 32'(act_ev[i].d), 32'(exp_ev[i].d));
        end
    endtask

    initial begin
        ev_t exp_ev[$];

        idle_inputs();
        reset_n = 1'b0;
        #1;
        check("reset.tvalid", 32'(bus.m_axis_out_tvalid), 32'h0);
        check("reset.tdata", 32'(bus.m_axis_out_tdata), 32'h0);
        check("reset.w_tvalid", 32'(wbus.m_axis_out_tvalid), 32'h0);
        check("reset.w_tdata", 32'(wbus.m_axis_out_tdata), 32'h0);

        // Constant 5 on every cycle. The 4th valid is accepted at cycle 3, so the first strobe is at cycle 7.
        tbl_clear(20);
        for (int i = 0; i < 16; i++) begin
            tbl[i].vld = 1'b1;
            tbl[i].x   = 16'd5;
        end
        tbl[7].exp_vld  = 1'b1; tbl[7].exp_data  = 16'd5;
        tbl[11].exp_vld = 1'b1; tbl[11].exp_data = 16'hfffb;
        tbl[15].exp_vld = 1'b1; tbl[15].exp_data = 16'd0;
        tbl[19].exp_vld = 1'b1; tbl[19].exp_data = 16'd0;
        tbl_hold();
        run_table("const5");

        // Ramp 0,1,2,... The decimated samples 3,7,11,15 give outputs 3,1,0,0.
        tbl_clear(20);
        for (int i = 0; i < 16; i++) begin
            tbl[i].vld = 1'b1;
            tbl[i].x   = 16'(i);
        end
        tbl[7].exp_vld  = 1'b1; tbl[7].exp_data  = 16'd3;
        tbl[11].exp_vld = 1'b1; tbl[11].exp_data = 16'd1;
        tbl[15].exp_vld = 1'b1; tbl[15].exp_data = 16'd0;
        tbl[19].exp_vld = 1'b1; tbl[19].exp_data = 16'd0;
        tbl_hold();
        run_table("ramp");

        // Ramp where tvalid alternates 1/0. Data on the idle cycles is junk and must be ignored.
        tbl_clear(35);
        for (int i = 0; i < 32; i++) begin
            tbl[i].vld = (i % 2 == 0);
            tbl[i].x   = (i % 2 == 0) ? 16'(i / 2) : 16'h7fff;
        end
        tbl[10].exp_vld = 1'b1; tbl[10].exp_data = 16'd3;
        tbl[18].exp_vld = 1'b1; tbl[18].exp_data = 16'd1;
        tbl[26].exp_vld = 1'b1; tbl[26].exp_data = 16'd0;
        tbl[34].exp_vld = 1'b1; tbl[34].exp_data = 16'd0;
        tbl_hold();
        run_table("ramp_gap");

        // Rate load in the same cycle as a valid sample, then a load of rate 0.
        do_reset();
        got.delete();
        cyc = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 1'b0, 32'd0);
        step(1'b1, 16'd8, 1'b1, 32'd2);
        for (int i = 9; i < 13; i++) step(1'b1, 16'(i), 1'b0, 32'd0);
        step(1'b0, 16'd0, 1'b1, 32'd0);
        step(1'b1, 16'd13, 1'b0, 32'd0);
        step(1'b1, 16'd14, 1'b0, 32'd0);
        for (int i = 0; i < 9; i++) step(1'b0, 16'd0, 1'b0, 32'd0);
        exp_ev.delete();
`ifdef CIC_VARIABLE_RATE_EN
        exp_ev.push_back('{7, 16'd3});
        exp_ev.push_back('{11, 16'd1});
        exp_ev.push_back('{14, 16'hffff});
        exp_ev.push_back('{16, 16'hffff});
        exp_ev.push_back('{18, 16'hffff});
        exp_ev.push_back('{19, 16'd0});
`else
        // With a fixed rate the loads are ignored, so one sample in four is still taken.
        exp_ev.push_back('{7, 16'd3});
        exp_ev.push_back('{11, 16'd1});
        exp_ev.push_back('{15, 16'd0});
`endif
        check_events("rate", exp_ev, got);

        // Wrap-around: 127 then -128 gives 127, then -255 wrapped to 1.
        do_reset();
        wgot.delete();
        cyc = 0;
        wbus.s_axis_in_tvalid = 1'b1;
        wbus.s_axis_in_tdata  = 8'h7f;
        step(1'b0, 16'd0, 1'b0, 32'd0);
        wbus.s_axis_in_tdata  = 8'h80;
        step(1'b0, 16'd0, 1'b0, 32'd0);
        wbus.s_axis_in_tvalid = 1'b0;
        wbus.s_axis_in_tdata  = 8'h00;
        for (int i = 0; i < 5; i++) step(1'b0, 16'd0, 1'b0, 32'd0);
        exp_ev.delete();
        exp_ev.push_back('{3, 16'h007f});
        exp_ev.push_back('{4, 16'h0001});
        check_events("wrap", exp_ev, wgot);

        // Reset while a sample is still in the pipeline.
        do_reset();
        got.delete();
        cyc = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 16'd5, 1'b0, 32'd0);
        step(1'b0, 16'd0, 1'b0, 32'd0);
        step(1'b0, 16'd0, 1'b0, 32'd0);
        reset_n = 1'b0;
        #1;
        check("midreset.tvalid", 32'(bus.m_axis_out_tvalid), 32'h0);
        check("midreset.tdata", 32'(bus.m_axis_out_tdata), 32'h0);
        bus.s_axis_in_tvalid = 1'b1;
        bus.s_axis_in_tdata  = 16'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("inreset[%0d].tvalid", i), 32'(bus.m_axis_out_tvalid), 32'h0);
        end
        reset_n = 1'b1;
        got.delete();
        cyc = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 16'd9, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 16'd0, 1'b0, 32'd0);
        check("postreset.count", 32'(got.size()), 32'h0);
        check("postreset.tdata", 32'(bus.m_axis_out_tdata), 32'h0);
        step(1'b1, 16'd9, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 16'd0, 1'b0, 32'd0);
        exp_ev.delete();
        exp_ev.push_back('{13, 16'd9});
        check_events("postreset", exp_ev, got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
